gsr_pur_assign_gen: RTL and testbench

Generates the chip-wide power-up reset (PUR) and global set/reset (GSR) nets consumed by primitive models and user logic. Both outputs are active-low: 1 means released, 0 means reset asserted. Consumers form their reset as GSR_sig & PUR_sig. Sits at top level, one instance per design; it replaces per-primitive hard-wired global nets.

---
 rtl/gsr_pur_assign_gen.sv | 88 ++++++++
 tb/tb_gsr_pur_assign_gen.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gsr_pur_assign_gen.sv
// Chip-wide power-up reset (PUR_sig) and global set/reset (GSR_sig) generator, both active-low.
// Optional macro GSR_SW_EN adds a synchronous software GSR request input sw_gsr.
module gsr_pur_assign_gen #(
  parameter int PUR_CYCLES      = 16,
  parameter int GSR_SYNC_STAGES = 2,
  parameter int GSR_MIN_PULSE   = 4,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             RSTB,
  input  logic             gsr_n_in,
`ifdef GSR_SW_EN
  input  logic             sw_gsr,
`endif
  output logic             GSR_sig,
  output logic             PUR_sig,
  output logic             ready,
  output logic [CNT_W-1:0] gsr_count
);

  localparam int PUR_W = 8;
  localparam int STR_W = (GSR_MIN_PULSE > 1) ? $clog2(GSR_MIN_PULSE) : 1;

  logic [PUR_W-1:0]           pur_cnt_q, pur_cnt_d;
  logic                       pur_q, pur_d;
  logic                       gsr_q, gsr_d;
  logic [STR_W-1:0]           str_q, str_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [GSR_SYNC_STAGES-1:0] sync_q, sync_d;
  logic                       req;

  always_comb begin
    sync_d = {sync_q[GSR_SYNC_STAGES-2:0], gsr_n_in};
    req    = ~sync_q[GSR_SYNC_STAGES-1];
`ifdef GSR_SW_EN
    req    = req | sw_gsr;
`endif

    pur_cnt_d = pur_cnt_q;
    if (pur_cnt_q != PUR_W'(PUR_CYCLES))
      pur_cnt_d = pur_cnt_q + 1'b1;
    pur_d = pur_q | (pur_cnt_q == PUR_W'(PUR_CYCLES - 1));

    gsr_d = gsr_q;
    str_d = str_q;
    cnt_d = cnt_q;
    if (!pur_q) begin
      gsr_d = 1'b0;
      str_d = '0;
    end else if (gsr_q) begin
      if (req) begin
        gsr_d = 1'b0;
        str_d = STR_W'(GSR_MIN_PULSE - 1);
        if (cnt_q != '1)
          cnt_d = cnt_q + 1'b1;
      end
    end else if (str_q != '0) begin
      str_d = str_q - 1'b1;
    end else if (!req) begin
      // Same path releases GSR at power-up (stretch is 0 then) and after a pulse.
      gsr_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (RSTB) begin
      pur_cnt_q <= '0;
      pur_q     <= 1'b0;
      gsr_q     <= 1'b0;
      str_q     <= '0;
      cnt_q     <= '0;
      sync_q    <= '1;
    end else begin
      pur_cnt_q <= pur_cnt_d;
      pur_q     <= pur_d;
      gsr_q     <= gsr_d;
      str_q     <= str_d;
      cnt_q     <= cnt_d;
      sync_q    <= sync_d;
    end
  end

  assign GSR_sig   = gsr_q;
  assign PUR_sig   = pur_q;
  assign ready     = gsr_q & pur_q;
  assign gsr_count = cnt_q;

endmodule

// File: tb/tb_gsr_pur_assign_gen.sv
// Self-checking bench for gsr_pur_assign_gen against an edge-indexed behavioural model.
module tb_gsr_pur_assign_gen;

  localparam int P = 16;
  localparam int N = 2;
  localparam int M = 4;

  logic       clk;
  logic       RSTB;
  logic       gsr_n_in;
  logic       sw_gsr;
  logic       GSR_sig;
  logic       PUR_sig;
  logic       ready;
  logic [7:0] gsr_count;

  int vectors = 0;
  int miscompares = 0;

  gsr_pur_assign_gen #(
    .PUR_CYCLES(P),
    .GSR_SYNC_STAGES(N),
    .GSR_MIN_PULSE(M),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .RSTB(RSTB),
    .gsr_n_in(gsr_n_in),
`ifdef GSR_SW_EN
    .sw_gsr(sw_gsr),
`endif
    .GSR_sig(GSR_sig),
    .PUR_sig(PUR_sig),
    .ready(ready),
    .gsr_count(gsr_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: n = edges since reset release, hist[j-1] = gsr_n_in sampled at edge j.
  int   n = 0;
  bit   hist[$];
  bit   m_gsr = 0;
  bit   m_pur = 0;
  int   events = 0;
  int   rel_at = 0;

  function automatic logic [7:0] exp_cnt();
    return (events > 255) ? 8'd255 : 8'(events);
  endfunction

  function automatic logic [10:0] exp_vec();
    return {m_gsr, m_pur, m_gsr & m_pur, exp_cnt()};
  endfunction

  function automatic logic [10:0] got_vec();
    return {GSR_sig, PUR_sig, ready, gsr_count};
  endfunction

  task automatic model_edge(input bit rst, input bit gin, input bit sw);
    bit pur_before;
    bit s;
    if (rst) begin
      n = 0;
      hist.delete();
      m_gsr = 0;
      m_pur = 0;
      events = 0;
      rel_at = 0;
    end else begin
      pur_before = (n >= P);
      n++;
      s = (n > N) ? hist[n-N-1] : 1'b1;
      hist.push_back(gin);
      if (!pur_before) m_gsr = 0;
      else if (m_gsr) begin
        if (!s || sw) begin
          m_gsr = 0;
          rel_at = n + M;
          events++;
        end
      end else if (n >= rel_at && s && !sw) m_gsr = 1;
      m_pur = (n >= P);
    end
  endtask

  task automatic step(input bit rst, input bit gin, input bit sw);
    RSTB = rst;
    gsr_n_in = gin;
    sw_gsr = sw;
    @(posedge clk);
    model_edge(rst, gin, sw);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0);
      vectors++;
      if (got_vec() !== 11'b0) begin
        miscompares++;
        $display("FAIL reset cyc %0d: got %b want %b", i, got_vec(), 11'b0);
      end
    end
  endtask

  task automatic test_pur_release();
    for (int i = 1; i <= P + 1; i++) begin
      step(0, 1, 0);
      vectors++;
      if (got_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL pur_model edge %0d: got %b want %b", i, got_vec(), exp_vec());
      end
    end
    // Independent of the model: after P+1 edges everything is released with no events.
    vectors++;
    if (got_vec() !== {3'b111, 8'd0}) begin
      miscompares++;
      $display("FAIL pur_released: got %b want %b", got_vec(), {3'b111, 8'd0});
    end
  endtask

  task automatic test_pur_edge_exact();
    logic [1:0] at_p1, at_p;
    step(1, 1, 0);
    for (int i = 1; i <= P + 1; i++) begin
      step(0, 1, 0);
      if (i == P - 1) at_p1 = {PUR_sig, GSR_sig};
      if (i == P) at_p = {PUR_sig, GSR_sig};
    end
    vectors++;
    if (at_p1 !== 2'b00 || at_p !== 2'b10 || GSR_sig !== 1'b1) begin
      miscompares++;
      $display("FAIL pur_edge: got P-1=%b P=%b gsr=%b want 00 10 1", at_p1, at_p, GSR_sig);
    end
  endtask

  task automatic run_pulse(input string name, input int low_len, input int expect_width);
    int first_low = 0;
    int width = 0;
    int cnt_before = events;
    for (int k = 1; k <= low_len + 12; k++) begin
      step(0, (k <= low_len) ? 1'b0 : 1'b1, 0);
      vectors++;
      if (got_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL %s_model k %0d: got %b want %b", name, k, got_vec(), exp_vec());
      end
      if (!GSR_sig) begin
        width++;
        if (first_low == 0) first_low = k;
      end
    end
    vectors++;
    if (first_low != N + 1 || width != expect_width) begin
      miscompares++;
      $display("FAIL %s_shape: got lat=%0d width=%0d want lat=%0d width=%0d",
               name, first_low, width, N + 1, expect_width);
    end
    vectors++;
    if (gsr_count !== 8'(cnt_before + 1)) begin
      miscompares++;
      $display("FAIL %s_count: got %0d want %0d", name, gsr_count, cnt_before + 1);
    end
  endtask

  task automatic test_short_pulse();
    run_pulse("short_pulse", 1, M);
  endtask

  task automatic test_long_pulse();
    run_pulse("long_pulse", 10, 10);
  endtask

  task automatic test_held_low_through_pur();
    step(1, 0, 0);
    for (int k = 1; k <= 26; k++) begin
      step(0, (k <= 20) ? 1'b0 : 1'b1, 0);
      vectors++;
      if (got_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL held_low_model k %0d: got %b want %b", k, got_vec(), exp_vec());
      end
      if (k == 22) begin
        vectors++;
        if ({GSR_sig, PUR_sig} !== 2'b01) begin
          miscompares++;
          $display("FAIL held_low_k22: got gsr/pur %b want 01", {GSR_sig, PUR_sig});
        end
      end
    end
    vectors++;
    if (got_vec() !== {3'b111, 8'd0}) begin
      miscompares++;
      $display("FAIL held_low_end: got %b want %b", got_vec(), {3'b111, 8'd0});
    end
  endtask

  task automatic test_reset_mid_stretch();
    int rise = 0;
    step(0, 0, 0);
    for (int k = 0; k < 3; k++) step(0, 1, 0);
    step(1, 1, 0);
    vectors++;
    if (got_vec() !== 11'b0) begin
      miscompares++;
      $display("FAIL mid_stretch_rst: got %b want %b", got_vec(), 11'b0);
    end
    for (int k = 1; k <= P + 2; k++) begin
      step(0, 1, 0);
      if (PUR_sig && rise == 0) rise = k;
      vectors++;
      if (got_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL mid_stretch_model k %0d: got %b want %b", k, got_vec(), exp_vec());
      end
    end
    vectors++;
    if (rise != P) begin
      miscompares++;
      $display("FAIL mid_stretch_pur: got rise at %0d want %0d", rise, P);
    end
  endtask

  task automatic test_random();
    bit rst, gin;
    int run = 0;
    gin = 1;
    for (int k = 0; k < 800; k++) begin
      rst = ($urandom_range(0, 199) == 0);
      if (run == 0) begin
        gin = ~gin;
        run = gin ? $urandom_range(1, 20) : $urandom_range(1, 8);
      end
      run--;
      step(rst, gin, 0);
      vectors++;
      if (got_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL random k %0d: got %b want %b", k, got_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_saturate();
    step(1, 1, 0);
    for (int k = 0; k < P + 2; k++) step(0, 1, 0);
    for (int p = 0; p < 300; p++) begin
      for (int k = 0; k < 10; k++) begin
        step(0, (k == 0) ? 1'b0 : 1'b1, 0);
        vectors++;
        if (got_vec() !== exp_vec()) begin
          miscompares++;
          $display("FAIL saturate_model p %0d k %0d: got %b want %b", p, k, got_vec(), exp_vec());
        end
      end
    end
    vectors++;
    if (gsr_count !== 8'd255) begin
      miscompares++;
      $display("FAIL saturate_count: got %0d want 255", gsr_count);
    end
  endtask

`ifdef GSR_SW_EN
  task automatic test_sw_gsr();
    int width = 0;
    bit lat_ok;
    step(0, 1, 1);
    lat_ok = (GSR_sig == 1'b0);
    for (int k = 0; k < 8; k++) begin
      if (!GSR_sig) width++;
      vectors++;
      if (got_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL sw_model k %0d: got %b want %b", k, got_vec(), exp_vec());
      end
      step(0, 1, 0);
    end
    vectors++;
    if (!lat_ok || width != M) begin
      miscompares++;
      $display("FAIL sw_shape: got lat_ok=%0d width=%0d want 1 %0d", lat_ok, width, M);
    end
  endtask
`endif

  initial begin
    RSTB = 1'b1;
    gsr_n_in = 1'b1;
    sw_gsr = 1'b0;
    test_reset();
    test_pur_release();
    test_short_pulse();
    test_long_pulse();
    test_pur_edge_exact();
    test_held_low_through_pur();
    test_short_pulse();
    test_reset_mid_stretch();
    test_random();
    test_saturate();
`ifdef GSR_SW_EN
    test_sw_gsr();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
